// File: rtl/cmp_operand_sequencer_if.sv
// Operand and result streams of the comparator sequencer.
// The slave modport is the sequencer's view and the master modport is the producer/consumer view.
interface cmp_operand_sequencer_if;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 2;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  out_a;
  logic [OP_W-1:0]  out_b;
  logic [RES_W-1:0] out_res;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_res, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_res, out_err
  );
endinterface

// File: rtl/cmp_operand_sequencer.sv
// Sequencer in front of the registered 4-bit priority comparator. It holds the operands
// for LATENCY cycles, samples the one-hot result, streams it out and keeps outcome statistics.
module cmp_operand_sequencer #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  cmp_operand_sequencer_if.slave bus,
  output logic [3:0]             cmp_a,
  output logic [3:0]             cmp_b,
  input  logic                   cmp_gt,
  input  logic                   cmp_eq,
  input  logic                   cmp_lt,
  output logic [CNT_W-1:0]       gt_cnt,
  output logic [CNT_W-1:0]       eq_cnt,
  output logic [CNT_W-1:0]       lt_cnt,
  output logic [CNT_W-1:0]       err_cnt
);
  localparam int unsigned       WAIT_W = 3;
  localparam logic [WAIT_W-1:0] LAT    = WAIT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              sample_c;
  logic [1:0]        res_c;
  logic              err_c;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign sample_c      = (state == WAIT) && (wait_cnt == LAT);

  // Encode the comparator flags; anything that is not one-hot becomes the error code.
  always_comb begin
    res_c = 2'b11;
    err_c = 1'b1;
    case ({cmp_gt, cmp_eq, cmp_lt})
      3'b100:  begin res_c = 2'b10; err_c = 1'b0; end
      3'b010:  begin res_c = 2'b01; err_c = 1'b0; end
      3'b001:  begin res_c = 2'b00; err_c = 1'b0; end
      default: ;
    endcase
  end

  // Operand capture, latency wait and output hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmp_a       <= '0;
      cmp_b       <= '0;
      bus.out_a   <= '0;
      bus.out_b   <= '0;
      bus.out_res <= 2'b00;
      bus.out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cmp_a     <= bus.in_a;
            cmp_b     <= bus.in_b;
            bus.out_a <= bus.in_a;
            bus.out_b <= bus.in_b;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == LAT) begin
            bus.out_res <= res_c;
            bus.out_err <= err_c;
            state       <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Saturating statistics; clr wins over an increment on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      lt_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      lt_cnt  <= '0;
      err_cnt <= '0;
    end else if (sample_c) begin
      if (err_c) begin
        err_cnt <= sat_inc(err_cnt);
      end else begin
        case (res_c)
          2'b10:   gt_cnt <= sat_inc(gt_cnt);
          2'b01:   eq_cnt <= sat_inc(eq_cnt);
          default: lt_cnt <= sat_inc(lt_cnt);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// Bench for cmp_operand_sequencer: two instances (LATENCY=1/CNT_W=2 and LATENCY=3/CNT_W=8),
// each with a behavioural registered comparator, checked against a queue of expected results.
module tb_cmp_operand_sequencer;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned CNT_A = 2;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned CNT_B = 8;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       err;
    logic [1:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic rst_a, rst_b, clr_a, clr_b;
  logic force_en;
  logic [2:0] force_val;

  cmp_operand_sequencer_if if_a ();
  cmp_operand_sequencer_if if_b ();

  logic [3:0] ca_a, cb_a, ca_b, cb_b;
  logic gt_a, eq_a, lt_a, gt_b, eq_b, lt_b;
  logic [CNT_A-1:0] gtc_a, eqc_a, ltc_a, errc_a;
  logic [CNT_B-1:0] gtc_b, eqc_b, ltc_b, errc_b;

  cmp_operand_sequencer #(.LATENCY(LAT_A), .CNT_W(CNT_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .clr(clr_a), .bus(if_a),
    .cmp_a(ca_a), .cmp_b(cb_a), .cmp_gt(gt_a), .cmp_eq(eq_a), .cmp_lt(lt_a),
    .gt_cnt(gtc_a), .eq_cnt(eqc_a), .lt_cnt(ltc_a), .err_cnt(errc_a)
  );

  cmp_operand_sequencer #(.LATENCY(LAT_B), .CNT_W(CNT_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .bus(if_b),
    .cmp_a(ca_b), .cmp_b(cb_b), .cmp_gt(gt_b), .cmp_eq(eq_b), .cmp_lt(lt_b),
    .gt_cnt(gtc_b), .eq_cnt(eqc_b), .lt_cnt(ltc_b), .err_cnt(errc_b)
  );

  function automatic logic [2:0] cmp_ref(input logic [3:0] a, input logic [3:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // Returns {err, res} for a comparator flag pattern.
  function automatic logic [2:0] enc_ref(input logic [2:0] p);
    case (p)
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      3'b001:  return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  // Comparator models: LATENCY register stages, reset by rst_n = ~rst.
  logic [2:0] pipe_a;
  logic [2:0] pipe_b [LAT_B];

  always @(posedge clk or negedge (~rst_a)) begin
    if (rst_a) pipe_a <= '0;
    else       pipe_a <= cmp_ref(ca_a, cb_a);
  end
  assign {gt_a, eq_a, lt_a} = force_en ? force_val : pipe_a;

  always @(posedge clk or negedge (~rst_b)) begin
    if (rst_b) begin
      for (int i = 0; i < LAT_B; i++) pipe_b[i] <= '0;
    end else begin
      pipe_b[0] <= cmp_ref(ca_b, cb_b);
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign {gt_b, eq_b, lt_b} = pipe_b[LAT_B-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  exp_t q_a[$];
  exp_t q_b[$];
  int unsigned acc_cyc_a = 0, acc_cyc_b = 0;
  int unsigned emit_a = 0, emit_b = 0;
  logic ov_prev_a = 1'b0, ov_prev_b = 1'b0;

  // Output monitors: latency on each out_valid rise, payload on each handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (if_a.out_valid && !ov_prev_a) check("latency_a", cyc - acc_cyc_a, LAT_A + 1);
    ov_prev_a <= if_a.out_valid;
    if (if_a.out_valid && if_a.out_ready) begin
      emit_a <= emit_a + 1;
      if (q_a.size() == 0) begin
        check("spurious_out_a", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("out_a_a", 32'(if_a.out_a), 32'(e.a));
        check("out_b_a", 32'(if_a.out_b), 32'(e.b));
        check("out_res_a", 32'(if_a.out_res), 32'(e.res));
        check("out_err_a", 32'(if_a.out_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (if_b.out_valid && !ov_prev_b) check("latency_b", cyc - acc_cyc_b, LAT_B + 1);
    ov_prev_b <= if_b.out_valid;
    if (if_b.out_valid && if_b.out_ready) begin
      emit_b <= emit_b + 1;
      if (q_b.size() == 0) begin
        check("spurious_out_b", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("out_a_b", 32'(if_b.out_a), 32'(e.a));
        check("out_b_b", 32'(if_b.out_b), 32'(e.b));
        check("out_res_b", 32'(if_b.out_res), 32'(e.res));
        check("out_err_b", 32'(if_b.out_err), 32'(e.err));
      end
    end
  end

  task automatic send_a(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    if_a.in_valid = 1'b1;
    if_a.in_a     = a;
    if_a.in_b     = b;
    while (!if_a.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout_a", 0, 1);
    e.a = a;
    e.b = b;
    {e.err, e.res} = enc_ref(force_en ? force_val : cmp_ref(a, b));
    q_a.push_back(e);
    @(posedge clk); #1;
    acc_cyc_a     = cyc;
    if_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    if_b.in_valid = 1'b1;
    if_b.in_a     = a;
    if_b.in_b     = b;
    while (!if_b.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout_b", 0, 1);
    e.a = a;
    e.b = b;
    {e.err, e.res} = enc_ref(cmp_ref(a, b));
    q_b.push_back(e);
    @(posedge clk); #1;
    acc_cyc_b     = cyc;
    if_b.in_valid = 1'b0;
  endtask

  task automatic drain_a;
    int n = 0;
    while ((q_a.size() != 0 || !if_a.in_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("drain_timeout_a", 0, 1);
  endtask

  task automatic drain_b;
    int n = 0;
    while ((q_b.size() != 0 || !if_b.in_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("drain_timeout_b", 0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned acc_prev;
    int unsigned emit0;
    int n;
    logic seen_ov;

    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    force_en = 1'b0; force_val = 3'b000;
    if_a.in_valid = 1'b0; if_a.in_a = '0; if_a.in_b = '0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_a = '0; if_b.in_b = '0; if_b.out_ready = 1'b1;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("rst_out_valid", 32'(if_a.out_valid), 0);
    check("rst_out_res_err", 32'({if_a.out_res, if_a.out_err}), 0);
    check("rst_ops", 32'({ca_a, cb_a, if_a.out_a, if_a.out_b}), 0);
    check("rst_cnts", 32'({gtc_a, eqc_a, ltc_a, errc_a}), 0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(if_a.in_ready), 1);

    // Single gt comparison.
    send_a(4'd9, 4'd3);
    drain_a();
    check("gt_cnt_first", 32'(gtc_a), 1);

    // Back-to-back stream: accepts spaced LATENCY+3 apart.
    send_a(4'd5, 4'd5);
    acc_prev = acc_cyc_a;
    send_a(4'd2, 4'd14);
    check("spacing_1", acc_cyc_a - acc_prev, LAT_A + 3);
    acc_prev = acc_cyc_a;
    send_a(4'd0, 4'd15);
    check("spacing_2", acc_cyc_a - acc_prev, LAT_A + 3);
    acc_prev = acc_cyc_a;
    send_a(4'd15, 4'd15);
    check("spacing_3", acc_cyc_a - acc_prev, LAT_A + 3);
    drain_a();
    check("eq_cnt_stream", 32'(eqc_a), 2);
    check("lt_cnt_stream", 32'(ltc_a), 2);

    // Downstream stall with a new pair pending.
    if_a.out_ready = 1'b0;
    send_a(4'd7, 4'd2);
    @(negedge clk);
    if_a.in_valid = 1'b1; if_a.in_a = 4'd1; if_a.in_b = 4'd8;
    n = 0;
    while (!if_a.out_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_out_valid_seen", 32'(if_a.out_valid), 1);
    emit0 = emit_a;
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", 32'(if_a.in_ready), 0);
      check("stall_hold", 32'({if_a.out_valid, if_a.out_a, if_a.out_b, if_a.out_res, if_a.out_err}),
            32'({1'b1, 4'd7, 4'd2, 2'b10, 1'b0}));
      @(negedge clk);
    end
    check("stall_no_emit", emit_a, emit0);
    @(posedge clk); #1 if_a.out_ready = 1'b1;
    send_a(4'd1, 4'd8);
    check("stall_one_emit", emit_a, emit0 + 1);
    drain_a();
    check("gt_cnt_stall", 32'(gtc_a), 2);
    check("lt_cnt_stall", 32'(ltc_a), 3);

    // Non-one-hot result (gt and lt both set).
    @(posedge clk); #1 force_en = 1'b1; force_val = 3'b101;
    send_a(4'd3, 4'd3);
    drain_a();
    force_en = 1'b0;
    check("err_cnt_forced", 32'(errc_a), 1);
    check("others_unchanged", 32'({gtc_a, eqc_a, ltc_a}), 32'({2'd2, 2'd2, 2'd3}));

    // Clear, then saturation at 2^CNT_W-1.
    @(posedge clk); #1 clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    check("clr_idle", 32'({gtc_a, eqc_a, ltc_a, errc_a}), 0);
    for (int i = 0; i < 5; i++) send_a(4'd10, 4'd1);
    drain_a();
    check("gt_saturate", 32'(gtc_a), 3);

    // clr coincident with the sampling edge drops that sample.
    send_a(4'd12, 4'd4);
    repeat (LAT_A) @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    check("clr_on_sample", 32'(gtc_a), 0);
    drain_a();
    check("clr_on_sample_after", 32'({gtc_a, eqc_a, ltc_a, errc_a}), 0);

    // LATENCY=3 instance: normal pair, then reset in WAIT.
    send_b(4'd4, 4'd1);
    drain_b();
    check("gt_cnt_b", 32'(gtc_b), 1);
    send_b(4'd6, 4'd6);
    @(posedge clk); #2 rst_b = 1'b1;
    #1;
    check("rst_wait_outs", 32'({if_b.out_valid, ca_b, cb_b, if_b.out_a, if_b.out_b,
                                if_b.out_res, if_b.out_err}), 0);
    check("rst_wait_cnts", 32'({gtc_b, eqc_b, ltc_b, errc_b}), 0);
    void'(q_b.pop_back());
    @(posedge clk); #1 rst_b = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_b.out_valid) seen_ov = 1'b1;
    end
    check("rst_no_out_valid", 32'(seen_ov), 0);
    check("rst_in_ready_b", 32'(if_b.in_ready), 1);
    send_b(4'd3, 4'd12);
    drain_b();
    check("after_rst_cnts", 32'({gtc_b, eqc_b, ltc_b, errc_b}), 32'({8'd0, 8'd0, 8'd1, 8'd0}));
    check("emit_b_total", emit_b, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
